fsm_multi_rule: RTL and testbench

Parametrised flow statistics block: one instance replaces a bank of single-rule flow counters on the receive port. It parses 134-bit FAST-format packets and extracts the IPv4 5-tuple. The tuple is matched against N masked rules in first-match or all-match mode, and per-rule packet and byte counters are kept. Counters saturate and are read through a registered index-addressed port.

---
 rtl/fsm_pkg.sv | 51 +++++
 rtl/fsm_tuple_extract.sv | 53 +++++
 rtl/fsm_multi_rule.sv | 244 ++++++++++++++++++++++++
 tb/tb_fsm_multi_rule.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the multi-rule flow statistics block:
// tuple width, FAST flag encodings, tuple byte offsets, FSM states and
// the saturating adder used by every counter.
package fsm_pkg;

    localparam int TUPLE_W = 104;

    localparam logic [1:0] FLAG_HEAD   = 2'b01;
    localparam logic [1:0] FLAG_MIDDLE = 2'b11;
    localparam logic [1:0] FLAG_TAIL   = 2'b10;

    // Frame byte offsets (byte 0 = first byte after the metadata beats)
    localparam int OFF_PROTO = 23;
    localparam int OFF_SIP   = 26;
    localparam int OFF_DIP   = 30;
    localparam int OFF_SPORT = 34;
    localparam int OFF_DPORT = 36;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PARSE,
        ST_MATCH,
        ST_WAIT_TAIL,
        ST_UPDATE
    } state_t;

    // Saturating add: result clamps at max instead of wrapping
    function automatic logic [63:0] sat_add(input logic [63:0] val,
                                            input logic [63:0] inc,
                                            input logic [63:0] max);
        logic [64:0] sum;
        sum = {1'b0, val} + {1'b0, inc};
        if (sum > {1'b0, max})
            return max;
        return sum[63:0];
    endfunction

    // Frame byte feeding tuple byte j; j = 0 is the MSB of {sip,dip,sport,dport,proto}
    function automatic int tuple_byte_off(input int j);
        if (j < 4)
            return OFF_SIP + j;
        else if (j < 8)
            return OFF_DIP + j - 4;
        else if (j < 10)
            return OFF_SPORT + j - 8;
        else if (j < 12)
            return OFF_DPORT + j - 10;
        return OFF_PROTO;
    endfunction

endpackage

// File: rtl/fsm_tuple_extract.sv
// Beat counter and byte-lane capture of the IPv4 5-tuple from FAST beats.
// tuple_valid_o pulses on the beat that delivers the last tuple byte; the
// captured tuple is stable from the following cycle.
module fsm_tuple_extract
    import fsm_pkg::*;
#(
    parameter int META_BEATS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               beat_i,
    input  logic [127:0]       data_i,
    output logic [TUPLE_W-1:0] tuple_o,
    output logic               tuple_valid_o
);

    localparam int LAST_BEAT = META_BEATS + 2;
    localparam int BC_W      = $clog2(LAST_BEAT + 2);

    logic [BC_W-1:0]    beat_q;
    logic [TUPLE_W-1:0] tuple_q;

    function automatic logic [7:0] lane_byte(input logic [127:0] d, input int lane);
        logic [127:0] s;
        s = d >> (8 * (15 - lane));
        return s[7:0];
    endfunction

    // Beat index of the current packet; parks one past the last tuple beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            beat_q <= '0;
        else if (start_i)
            beat_q <= BC_W'(1);
        else if (beat_i && (int'(beat_q) <= LAST_BEAT))
            beat_q <= beat_q + 1'b1;
    end

    // Pick tuple bytes out of their lanes on the beats that carry them
    always_ff @(posedge clk) begin
        if (beat_i) begin
            for (int j = 0; j < TUPLE_W / 8; j++) begin
                if (int'(beat_q) == META_BEATS + tuple_byte_off(j) / 16)
                    tuple_q[TUPLE_W-1-8*j -: 8] <= lane_byte(data_i, tuple_byte_off(j) % 16);
            end
        end
    end

    assign tuple_o       = tuple_q;
    assign tuple_valid_o = beat_i && (int'(beat_q) == LAST_BEAT);

endmodule

// File: rtl/fsm_multi_rule.sv
// Multi-rule flow statistics monitor for a FAST receive port.
// Matches each packet's 5-tuple against N_RULES masked rules and keeps
// saturating per-rule packet/byte counters plus miss and runt counters.
// Optional feature macro: FSM_BYTE_CNT_EN builds byte counting; without it
// rd_byte_cnt reads 0.
module fsm_multi_rule
    import fsm_pkg::*;
#(
    parameter int  N_RULES    = 8,
    parameter int  CNT_W      = 32,
    parameter int  BYTE_W     = 48,
    parameter int  META_BEATS = 2,
    parameter int  MATCH_MODE = 0,
    localparam int IDX_W      = $clog2(N_RULES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [133:0]       pktin_data,
    input  logic               pktin_data_wr,
    input  logic               cnt_rst,
    input  logic               cfg_wr,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic               cfg_en,
    input  logic [TUPLE_W-1:0] cfg_tuple,
    input  logic [TUPLE_W-1:0] cfg_mask,
    input  logic               rd_req,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_ack,
    output logic [CNT_W-1:0]   rd_pkt_cnt,
    output logic [BYTE_W-1:0]  rd_byte_cnt,
    output logic [CNT_W-1:0]   miss_cnt,
    output logic [CNT_W-1:0]   runt_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0] flag;
    logic       is_head, is_mid, is_tail;
    logic       in_pkt, upd, runt_hit;

    state_t             state_q;
    logic               tail_q;
    logic [N_RULES-1:0] hit_q, hit_d, upd_sel;

    logic [TUPLE_W-1:0] tuple;
    logic               tuple_valid;

    logic [N_RULES-1:0] rule_en_q;
    logic [TUPLE_W-1:0] rule_tuple_q [N_RULES];
    logic [TUPLE_W-1:0] rule_mask_q  [N_RULES];

    logic [CNT_W-1:0]   pkt_cnt_q [N_RULES];
    logic [CNT_W-1:0]   miss_q, runt_q;
    logic               rd_ack_q;
    logic [CNT_W-1:0]   rd_pkt_q;

    assign flag     = pktin_data[133:132];
    assign is_head  = pktin_data_wr && (flag == FLAG_HEAD);
    assign is_mid   = pktin_data_wr && (flag == FLAG_MIDDLE);
    assign is_tail  = pktin_data_wr && (flag == FLAG_TAIL);
    assign in_pkt   = (state_q == ST_PARSE) || (state_q == ST_MATCH) || (state_q == ST_WAIT_TAIL);
    assign upd      = (state_q == ST_UPDATE);
    assign runt_hit = (state_q == ST_PARSE) && is_tail && !tuple_valid;

    fsm_tuple_extract #(
        .META_BEATS (META_BEATS)
    ) u_extract (
        .clk           (clk),
        .rst           (rst),
        .start_i       (is_head),
        .beat_i        ((state_q == ST_PARSE) && (is_mid || is_tail)),
        .data_i        (pktin_data[127:0]),
        .tuple_o       (tuple),
        .tuple_valid_o (tuple_valid)
    );

    // Rule enables start cleared so no rule matches until configured
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rule_en_q <= '0;
        else if (cfg_wr)
            rule_en_q[cfg_idx] <= cfg_en;
    end

    // Rule tuple and mask storage
    always_ff @(posedge clk) begin
        if (cfg_wr) begin
            rule_tuple_q[cfg_idx] <= cfg_tuple;
            rule_mask_q[cfg_idx]  <= cfg_mask;
        end
    end

    // Masked compare of the captured tuple against every rule, then counter selection
    always_comb begin
        logic found;
        hit_d   = '0;
        upd_sel = '0;
        found   = 1'b0;
        for (int i = 0; i < N_RULES; i++)
            hit_d[i] = rule_en_q[i] && (((tuple ^ rule_tuple_q[i]) & rule_mask_q[i]) == '0);
        if (MATCH_MODE == 1) begin
            upd_sel = hit_q;
        end else begin
            for (int i = 0; i < N_RULES; i++) begin
                if (hit_q[i] && !found) begin
                    upd_sel[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    // Packet walk: parse, match once, wait for tail, count; any head restarts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tail_q  <= 1'b0;
            hit_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_head)
                        state_q <= ST_PARSE;
                end
                ST_PARSE: begin
                    if (is_head) begin
                        state_q <= ST_PARSE;
                    end else if (tuple_valid) begin
                        state_q <= ST_MATCH;
                        tail_q  <= is_tail;
                    end else if (is_tail) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MATCH: begin
                    hit_q <= hit_d;
                    if (is_head)
                        state_q <= ST_PARSE;
                    else if (tail_q || is_tail)
                        state_q <= ST_UPDATE;
                    else
                        state_q <= ST_WAIT_TAIL;
                end
                ST_WAIT_TAIL: begin
                    if (is_head)
                        state_q <= ST_PARSE;
                    else if (is_tail)
                        state_q <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    state_q <= is_head ? ST_PARSE : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Packet, miss and runt counters; cnt_rst overrides a same-cycle update
    always_ff @(posedge clk or posedge rst) begin
        if (rst || cnt_rst) begin
            for (int i = 0; i < N_RULES; i++)
                pkt_cnt_q[i] <= '0;
            miss_q <= '0;
            runt_q <= '0;
        end else begin
            if (upd) begin
                for (int i = 0; i < N_RULES; i++) begin
                    if (upd_sel[i])
                        pkt_cnt_q[i] <= CNT_W'(sat_add(64'(pkt_cnt_q[i]), 64'd1, 64'(CNT_MAX)));
                end
                if (hit_q == '0)
                    miss_q <= CNT_W'(sat_add(64'(miss_q), 64'd1, 64'(CNT_MAX)));
            end
            if (runt_hit)
                runt_q <= CNT_W'(sat_add(64'(runt_q), 64'd1, 64'(CNT_MAX)));
        end
    end

    // Registered packet-count readout; value sampled before any same-cycle update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ack_q <= 1'b0;
            rd_pkt_q <= '0;
        end else begin
            rd_ack_q <= rd_req;
            if (rd_req)
                rd_pkt_q <= pkt_cnt_q[rd_idx];
        end
    end

`ifdef FSM_BYTE_CNT_EN
    localparam logic [BYTE_W-1:0] BYTE_MAX = '1;

    logic [15:0]       len_q;
    logic [15:0]       frame_len;
    logic [BYTE_W-1:0] byte_cnt_q [N_RULES];
    logic [BYTE_W-1:0] rd_byte_q;

    // Running byte total of the packet, metadata beats included
    always_ff @(posedge clk) begin
        if (is_head)
            len_q <= 16'd16;
        else if (in_pkt && is_mid)
            len_q <= len_q + 16'd16;
        else if (in_pkt && is_tail)
            len_q <= len_q + 16'd16 - {12'd0, pktin_data[131:128]};
    end

    assign frame_len = len_q - 16'(16 * META_BEATS);

    // Per-rule byte counters, cleared and updated alongside the packet counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst || cnt_rst) begin
            for (int i = 0; i < N_RULES; i++)
                byte_cnt_q[i] <= '0;
        end else if (upd) begin
            for (int i = 0; i < N_RULES; i++) begin
                if (upd_sel[i])
                    byte_cnt_q[i] <= BYTE_W'(sat_add(64'(byte_cnt_q[i]), 64'(frame_len), 64'(BYTE_MAX)));
            end
        end
    end

    // Registered byte-count readout
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_byte_q <= '0;
        else if (rd_req)
            rd_byte_q <= byte_cnt_q[rd_idx];
    end

    assign rd_byte_cnt = rd_byte_q;
`else
    logic unused_inv;
    assign unused_inv  = ^pktin_data[131:128];
    assign rd_byte_cnt = '0;
`endif

    assign rd_ack     = rd_ack_q;
    assign rd_pkt_cnt = rd_pkt_q;
    assign miss_cnt   = miss_q;
    assign runt_cnt   = runt_q;

endmodule

// File: tb/tb_fsm_multi_rule.sv
// Directed bench for fsm_multi_rule: first-match, all-match and a narrow
// counter instance driven by the same packet stream.
module tb_fsm_multi_rule;

    localparam int MB = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [133:0] pktin_data;
    logic         pktin_data_wr;
    logic         cnt_rst;
    logic         cfg_wr;
    logic [2:0]   cfg_idx;
    logic         cfg_en;
    logic [103:0] cfg_tuple;
    logic [103:0] cfg_mask;
    logic         rd_req;
    logic [2:0]   rd_idx;

    logic         ack0, ack1, acks;
    logic [31:0]  pkt0, pkt1, miss0, miss1, runt0, runt1;
    logic [47:0]  byte0, byte1;
    logic [3:0]   pkts, misss, runts;
    logic [7:0]   bytes_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsm_multi_rule #(.MATCH_MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .pktin_data(pktin_data), .pktin_data_wr(pktin_data_wr),
        .cnt_rst(cnt_rst), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_tuple(cfg_tuple), .cfg_mask(cfg_mask), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_ack(ack0), .rd_pkt_cnt(pkt0), .rd_byte_cnt(byte0), .miss_cnt(miss0), .runt_cnt(runt0)
    );

    fsm_multi_rule #(.MATCH_MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .pktin_data(pktin_data), .pktin_data_wr(pktin_data_wr),
        .cnt_rst(cnt_rst), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_tuple(cfg_tuple), .cfg_mask(cfg_mask), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_ack(ack1), .rd_pkt_cnt(pkt1), .rd_byte_cnt(byte1), .miss_cnt(miss1), .runt_cnt(runt1)
    );

    fsm_multi_rule #(.MATCH_MODE(0), .CNT_W(4), .BYTE_W(8)) u_sat (
        .clk(clk), .rst(rst), .pktin_data(pktin_data), .pktin_data_wr(pktin_data_wr),
        .cnt_rst(cnt_rst), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_tuple(cfg_tuple), .cfg_mask(cfg_mask), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_ack(acks), .rd_pkt_cnt(pkts), .rd_byte_cnt(bytes_s), .miss_cnt(misss), .runt_cnt(runts)
    );

    function automatic logic [63:0] bexp(input logic [63:0] v);
`ifdef FSM_BYTE_CNT_EN
        return v;
`else
        return 64'd0 & v;
`endif
    endfunction

    function automatic logic [63:0] bsat(input logic [63:0] v);
        return bexp((v > 64'd255) ? 64'd255 : v);
    endfunction

    // Tuple layout {sip[103:72], dip[71:40], sport[39:24], dport[23:8], proto[7:0]}
    function automatic logic [7:0] frame_byte(input logic [103:0] t, input int k);
        if (k == 23)              return t[7:0];
        if (k >= 26 && k <= 29)   return t[103-8*(k-26) -: 8];
        if (k >= 30 && k <= 33)   return t[71-8*(k-30) -: 8];
        if (k >= 34 && k <= 35)   return t[39-8*(k-34) -: 8];
        if (k >= 36 && k <= 37)   return t[23-8*(k-36) -: 8];
        return 8'(k * 7);
    endfunction

    function automatic logic [127:0] beat_data(input logic [103:0] t, input int b);
        logic [127:0] d;
        d = '0;
        for (int l = 0; l < 16; l++) begin
            if (b < MB)
                d[127-8*l -: 8] = 8'hC3;
            else
                d[127-8*l -: 8] = frame_byte(t, 16 * (b - MB) + l);
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [103:0] t, input int nb, input logic [3:0] inv,
                        input bit with_tail, input int idle);
        for (int b = 0; b < nb; b++) begin
            logic       last;
            logic [1:0] f;
            last = with_tail && (b == nb - 1);
            f    = (b == 0) ? 2'b01 : (last ? 2'b10 : 2'b11);
            pktin_data    = {f, last ? inv : 4'h0, beat_data(t, b)};
            pktin_data_wr = 1'b1;
            tick();
        end
        pktin_data_wr = 1'b0;
        repeat (idle) tick();
    endtask

    task automatic rd(input logic [2:0] idx);
        rd_req = 1'b1;
        rd_idx = idx;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] idx, input logic en, input logic [103:0] t, input logic [103:0] m);
        cfg_wr    = 1'b1;
        cfg_idx   = idx;
        cfg_en    = en;
        cfg_tuple = t;
        cfg_mask  = m;
        tick();
        cfg_wr = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [103:0] full, t0, t1, t2, t3, tm, m3;
        full = {104{1'b1}};
        t0   = {32'h0a000001, 32'h0a000002, 16'd1000, 16'd2000, 8'd17};
        t1   = {32'h0a000101, 32'h0a000102, 16'd5000, 16'd6000, 8'd6};
        t2   = {32'hc0a80001, 32'hc0a80002, 16'd80,   16'd443,  8'd17};
        t3   = {96'd0, 8'd6};
        m3   = {96'd0, 8'hFF};
        tm   = {32'h01020304, 32'h05060708, 16'd1,    16'd2,    8'd1};

        rst = 1'b1; pktin_data = '0; pktin_data_wr = 1'b0; cnt_rst = 1'b0;
        cfg_wr = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_tuple = '0; cfg_mask = '0;
        rd_req = 1'b0; rd_idx = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("reset_ack", 64'(ack0), 0);
        chk("reset_pkt", 64'(pkt0), 0);
        chk("reset_byte", 64'(byte0), 0);
        chk("reset_miss", 64'(miss0), 0);
        chk("reset_runt", 64'(runt0), 0);
        rd(3'd0);
        chk("reset_read_pkt", 64'(pkt0), 0);

        cfg(3'd0, 1'b1, t0, full);
        cfg(3'd1, 1'b1, t1, full);
        cfg(3'd2, 1'b1, t2, full);
        cfg(3'd3, 1'b1, t3, m3);

        // 64-byte frame on rule 0
        send(t0, 6, 4'd0, 1'b1, 2);
        rd(3'd0);
        chk("r0_ack", 64'(ack0), 1);
        chk("r0_pkt", 64'(pkt0), 1);
        chk("r0_byte", 64'(byte0), bexp(64));
        chk("r0_miss", 64'(miss0), 0);
        tick();
        chk("ack_pulse", 64'(ack0), 0);

        // Overlapping rules 1 and 3
        send(t1, 6, 4'd0, 1'b1, 2);
        rd(3'd1);
        chk("m0_r1_pkt", 64'(pkt0), 1);
        chk("m1_r1_pkt", 64'(pkt1), 1);
        rd(3'd3);
        chk("m0_r3_pkt", 64'(pkt0), 0);
        chk("m1_r3_pkt", 64'(pkt1), 1);
        chk("m1_r3_byte", 64'(byte1), bexp(64));

        // Tail on the tuple-complete beat, 45-byte frame
        send(t1, 5, 4'd3, 1'b1, 2);
        rd(3'd1);
        chk("m0_r1_pkt2", 64'(pkt0), 2);
        chk("m0_r1_byte2", 64'(byte0), bexp(109));
        rd(3'd3);
        chk("m0_r3_pkt2", 64'(pkt0), 0);
        chk("m1_r3_pkt2", 64'(pkt1), 2);
        chk("m1_r3_byte2", 64'(byte1), bexp(109));

        // Runt: tail at beat 3
        send(t0, 4, 4'd0, 1'b1, 2);
        chk("runt_cnt", 64'(runt0), 1);
        chk("runt_miss", 64'(miss0), 0);
        rd(3'd0);
        chk("runt_r0_pkt", 64'(pkt0), 1);

        // Unmatched full frame
        send(tm, 6, 4'd0, 1'b1, 2);
        chk("miss_m0", 64'(miss0), 1);
        chk("miss_m1", 64'(miss1), 1);

        // Read landing on the UPDATE cycle, then the next read
        send(t0, 6, 4'd0, 1'b1, 0);
        rd(3'd0);
        chk("upd_read_old", 64'(pkt0), 1);
        chk("upd_read_old_byte", 64'(byte0), bexp(64));
        rd(3'd0);
        chk("upd_read_new", 64'(pkt0), 2);
        chk("upd_read_new_byte", 64'(byte0), bexp(128));

        // Head arriving mid-packet aborts the first packet
        send(t0, 3, 4'd0, 1'b0, 0);
        send(t0, 6, 4'd0, 1'b1, 2);
        rd(3'd0);
        chk("abort_r0_pkt", 64'(pkt0), 3);
        chk("abort_r0_byte", 64'(byte0), bexp(192));
        chk("abort_runt", 64'(runt0), 1);
        chk("abort_miss", 64'(miss0), 1);

        // Back-to-back packets into a 4-bit counter
        for (int i = 0; i < 14; i++)
            send(t2, 6, 4'd0, 1'b1, 0);
        tick(); tick();
        rd(3'd2);
        chk("sat_pkt14", 64'(pkts), 14);
        chk("sat_byte14", 64'(bytes_s), bsat(14 * 64));
        chk("m0_r2_pkt14", 64'(pkt0), 14);
        send(t2, 6, 4'd0, 1'b1, 2);
        rd(3'd2);
        chk("sat_pkt15", 64'(pkts), 15);
        for (int i = 0; i < 3; i++)
            send(t2, 6, 4'd0, 1'b1, (i == 2) ? 2 : 0);
        rd(3'd2);
        chk("sat_pkt_hold", 64'(pkts), 15);
        chk("m0_r2_pkt18", 64'(pkt0), 18);
        chk("m0_r2_byte18", 64'(byte0), bexp(1152));

        // Disabled rule no longer matches
        cfg(3'd0, 1'b0, t0, full);
        send(t0, 6, 4'd0, 1'b1, 2);
        chk("dis_miss", 64'(miss0), 2);
        rd(3'd0);
        chk("dis_r0_pkt", 64'(pkt0), 3);

        // cnt_rst in the UPDATE cycle of a matching packet
        send(t2, 6, 4'd0, 1'b1, 0);
        cnt_rst = 1'b1;
        tick();
        cnt_rst = 1'b0;
        tick();
        rd(3'd2);
        chk("clr_r2_pkt", 64'(pkt0), 0);
        chk("clr_r2_byte", 64'(byte0), 0);
        chk("clr_sat_pkt", 64'(pkts), 0);
        rd(3'd1);
        chk("clr_r1_pkt_m1", 64'(pkt1), 0);
        chk("clr_miss", 64'(miss0), 0);
        chk("clr_runt", 64'(runt0), 0);

        // Counting resumes after the clear
        send(t2, 6, 4'd0, 1'b1, 2);
        rd(3'd2);
        chk("post_clr_r2_pkt", 64'(pkt0), 1);
        chk("post_clr_r2_byte", 64'(byte0), bexp(64));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
